// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver. Colours are captured on rgb_valid and
// applied only at a PWM period boundary so no period is ever cut short.
module rgb_pwm_driver #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    input  logic        rgb_valid,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start,
    output logic        pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic [7:0]    step_cnt;
    logic [23:0]   pend_reg;
    logic [7:0]    duty_r;
    logic [7:0]    duty_g;
    logic [7:0]    duty_b;
    logic          tick;
    logic          wrap;

    assign tick = (pre_cnt == PRE_LAST);
    assign wrap = tick && (step_cnt == 8'd255);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            step_cnt     <= '0;
            pend_reg     <= '0;
            pending      <= 1'b0;
            duty_r       <= '0;
            duty_g       <= '0;
            duty_b       <= '0;
            pwm_r        <= 1'b0;
            pwm_g        <= 1'b0;
            pwm_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick)
                step_cnt <= step_cnt + 8'd1;

            // Compare uses the duty and step of the current cycle, so the
            // outputs trail step_cnt by one clock.
            pwm_r        <= (step_cnt < duty_r);
            pwm_g        <= (step_cnt < duty_g);
            pwm_b        <= (step_cnt < duty_b);
            period_start <= wrap;

            if (rgb_valid)
                pend_reg <= rgb;

            // A valid landing on the wrap cycle bypasses the pending slot.
            if (wrap) begin
                if (rgb_valid) begin
                    duty_r  <= rgb[23:16];
                    duty_g  <= rgb[15:8];
                    duty_b  <= rgb[7:0];
                    pending <= 1'b0;
                end else if (pending) begin
                    duty_r  <= pend_reg[23:16];
                    duty_g  <= pend_reg[15:8];
                    duty_b  <= pend_reg[7:0];
                    pending <= 1'b0;
                end
            end else if (rgb_valid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=1, one at
// PRESCALE=3, with hand-computed high-time counts per PWM period.
module tb_rgb_pwm_driver;

    logic        clk;
    logic        rst, rst3;
    logic [23:0] rgb, rgb3;
    logic        vld, vld3;
    logic        r1, g1, b1, ps1, pend1;
    logic        r3, g3, b3, ps3, pend3;

    int total = 0;
    int bad   = 0;
    int hr, hg, hb, nps, fb, cnt;

    rgb_pwm_driver #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .rgb(rgb), .rgb_valid(vld),
        .pwm_r(r1), .pwm_g(g1), .pwm_b(b1),
        .period_start(ps1), .pending(pend1)
    );

    rgb_pwm_driver #(.PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst3), .rgb(rgb3), .rgb_valid(vld3),
        .pwm_r(r3), .pwm_g(g3), .pwm_b(b3),
        .period_start(ps3), .pending(pend3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for period_start, then count highs over one full period.
    task automatic measure(input bit sel, input int len,
                           output int h_r, output int h_g, output int h_b,
                           output int n_ps, output int first_b);
        int guard;
        guard   = 0;
        h_r     = 0;
        h_g     = 0;
        h_b     = 0;
        n_ps    = 0;
        first_b = -1;
        while (!(sel ? ps3 : ps1) && guard < 2 * len + 8) begin
            step();
            guard++;
        end
        chk("ps_found", 32'(sel ? ps3 : ps1), 32'd1);
        for (int k = 1; k <= len; k++) begin
            step();
            if (sel ? r3 : r1) h_r++;
            if (sel ? g3 : g1) h_g++;
            if (sel ? b3 : b1) begin
                h_b++;
                if (first_b < 0) first_b = k;
            end
            if (sel ? ps3 : ps1) n_ps++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        rgb  = 24'hFFFFFF;
        vld  = 1'b1;
        rst3 = 1'b1;
        rgb3 = 24'h0;
        vld3 = 1'b0;

        // T1 reset with a valid held high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_rst_outs", {27'd0, r1, g1, b1, ps1, pend1}, 32'd0);
        end
        rst = 1'b0;
        vld = 1'b0;
        rgb = 24'h0;
        step();
        chk("t1_after_rst", {27'd0, r1, g1, b1, ps1, pend1}, 32'd0);
        cnt = 0;
        nps = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (r1 || g1 || b1) cnt++;
            if (ps1) nps++;
        end
        chk("t1_no_pwm", cnt, 0);
        chk("t1_ps_cnt", nps, 1);

        // T2 basic duty
        rgb = 24'h804000;
        vld = 1'b1;
        step();
        vld = 1'b0;
        rgb = 24'h0;
        chk("t2_pending", pend1, 1'b1);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t2_hr", hr, 128);
        chk("t2_hg", hg, 64);
        chk("t2_hb", hb, 0);
        chk("t2_ps", nps, 1);
        chk("t2_pend_clr", pend1, 1'b0);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t2_hr_again", hr, 128);
        chk("t2_ps_again", nps, 1);

        // T3 extremes
        rgb = 24'hFF0001;
        vld = 1'b1;
        step();
        vld = 1'b0;
        rgb = 24'h0;
        chk("t3_pending", pend1, 1'b1);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t3_hr", hr, 255);
        chk("t3_hg", hg, 0);
        chk("t3_hb", hb, 1);
        chk("t3_b_first", fb, 1);

        // T4 valid on the wrap cycle: measure left us at step 0
        repeat (255) step();
        chk("t4_pre_pend", pend1, 1'b0);
        chk("t4_pre_ps", ps1, 1'b0);
        rgb = 24'h101010;
        vld = 1'b1;
        step();
        vld = 1'b0;
        rgb = 24'h0;
        chk("t4_ps", ps1, 1'b1);
        chk("t4_pend", pend1, 1'b0);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t4_hr", hr, 16);
        chk("t4_hg", hg, 16);
        chk("t4_hb", hb, 16);
        chk("t4_pend_after", pend1, 1'b0);

        // T5a overwrite: last valid wins
        repeat (10) step();
        rgb = 24'h202020;
        vld = 1'b1;
        step();
        vld = 1'b0;
        repeat (5) step();
        rgb = 24'hC0C0C0;
        vld = 1'b1;
        step();
        vld = 1'b0;
        rgb = 24'h0;
        chk("t5_pending", pend1, 1'b1);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t5_hr", hr, 192);
        chk("t5_hg", hg, 192);
        chk("t5_hb", hb, 192);

        // T5b reset mid-period drops the pending colour
        repeat (20) step();
        chk("t5_mid_r", r1, 1'b1);
        rgb = 24'h404040;
        vld = 1'b1;
        step();
        vld = 1'b0;
        rgb = 24'h0;
        chk("t5_mid_pend", pend1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_outs", {27'd0, r1, g1, b1, ps1, pend1}, 32'd0);
        measure(1'b0, 256, hr, hg, hb, nps, fb);
        chk("t5_rst_hr", hr, 0);
        chk("t5_rst_hg", hg, 0);
        chk("t5_rst_hb", hb, 0);

        // T5c basic duty at PRESCALE=3
        repeat (2) step();
        rst3 = 1'b0;
        step();
        rgb3 = 24'h804000;
        vld3 = 1'b1;
        step();
        vld3 = 1'b0;
        rgb3 = 24'h0;
        chk("t5p3_pending", pend3, 1'b1);
        measure(1'b1, 768, hr, hg, hb, nps, fb);
        chk("t5p3_hr", hr, 384);
        chk("t5p3_hg", hg, 192);
        chk("t5p3_hb", hb, 0);
        chk("t5p3_ps", nps, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
